// File: rtl/prio_mixer_n_if.sv
// rtl/prio_mixer_n_if.sv - save-state bus interface shared by state-holding blocks
//
// Signals:
//   idx   : slave index being addressed; a slave answers only when idx matches its SS_IDX
//   addr  : byte address inside the selected slave
//   wdata : write data
//   wr    : write strobe, one clk
//   rd    : read strobe, one clk
//   rdata : read data, registered by the slave
//   ack   : slave acknowledge, registered, high the clk after an accepted rd/wr
interface ssbus_if;
  logic [7:0] idx;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       wr;
  logic       rd;
  logic [7:0] rdata;
  logic       ack;

  modport master (output idx, addr, wdata, wr, rd, input rdata, ack);
  modport slave  (input idx, addr, wdata, wr, rd, output rdata, ack);
endinterface

// File: rtl/prio_mixer_n.sv
// rtl/prio_mixer_n.sv - N-layer priority mixer with optional nibble blend
//
// Optional build macro: PRIO_LAYER_MASK_EN (reg1 becomes a live layer mask).
//
// Ports:
//   clk, reset           : system clock, asynchronous active-high reset
//   ce_pixel             : pixel clock enable, advances the 2-stage pipeline
//   vblank               : vertical blank level, rising edge commits staged regs when latch_mode=1
//   cs, cpu_addr, cpu_rw : CPU register select / address / direction (1=read)
//   cpu_ds_n, cpu_din    : data strobes (bit 0 used) and write data
//   cpu_dout             : registered read data of the staged copy
//   color_in             : NUM_LAYERS slices of {sel, color}, layer k in slice k
//   color_out            : final palette index
//   layer_out            : index of the winning layer
//   ssbus                : save-state access to the staged register file
module prio_mixer_n #(
  parameter int NUM_LAYERS = 4,
  parameter int COLOR_W    = 12,
  parameter int SEL_W      = 2,
  parameter int ADDR_W     = 4,
  parameter int SS_IDX     = -1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ce_pixel,
  input  logic                                  vblank,
  input  logic                                  cs,
  input  logic [ADDR_W-1:0]                     cpu_addr,
  input  logic                                  cpu_rw,
  input  logic [1:0]                            cpu_ds_n,
  input  logic [7:0]                            cpu_din,
  output logic [7:0]                            cpu_dout,
  input  logic [NUM_LAYERS*(SEL_W+COLOR_W)-1:0] color_in,
  output logic [COLOR_W-1:0]                    color_out,
  output logic [2:0]                            layer_out,
  ssbus_if.slave                                ssbus
);

  localparam int NREGS   = 2 + 2*NUM_LAYERS;
  localparam int SLICE_W = SEL_W + COLOR_W;

`ifdef PRIO_LAYER_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  // staged copy is what the CPU and save-state bus see; live copy drives the pipeline
  logic [7:0] stg  [NREGS];
  logic [7:0] live [NREGS];
  logic       vb_prev;

  logic cpu_wr, cpu_rd, ss_sel, ss_wr, ss_rd, commit;
  assign cpu_wr = cs & ~cpu_rw & ~cpu_ds_n[0];
  assign cpu_rd = cs & cpu_rw;
  assign ss_sel = (SS_IDX >= 0) && (ssbus.idx == 8'(SS_IDX));
  assign ss_wr  = ss_sel & ssbus.wr;
  assign ss_rd  = ss_sel & ssbus.rd;

  // latch_mode is taken from the staged copy so that clearing it takes effect at once
  assign commit = ~stg[0][6] | (vblank & ~vb_prev);

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) stg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        // reg1 only has storage when the layer mask is built
        if (i != 1 || MASK_EN) begin
          if (ss_wr && ssbus.addr == 8'(i)) stg[i] <= ssbus.wdata;
          if (cpu_wr && cpu_addr == ADDR_W'(i)) stg[i] <= cpu_din;
        end
      end
    end
  end

  // a write landing on the commit clk updates stg at the same edge live samples
  // the old stg, so it naturally waits for the next commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb_prev <= 1'b0;
      for (int i = 0; i < NREGS; i++) live[i] <= '0;
    end else begin
      vb_prev <= vblank;
      if (commit) begin
        for (int i = 0; i < NREGS; i++) live[i] <= stg[i];
      end
    end
  end

  logic [7:0] cpu_rdata, ss_rdata;
  always_comb begin
    cpu_rdata = '0;
    ss_rdata  = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (cpu_addr == ADDR_W'(i)) cpu_rdata = stg[i];
      if (ssbus.addr == 8'(i))    ss_rdata  = stg[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_dout    <= '0;
      ssbus.rdata <= '0;
      ssbus.ack   <= 1'b0;
    end else begin
      if (cpu_rd) cpu_dout <= cpu_rdata;
      if (ss_rd)  ssbus.rdata <= ss_rdata;
      ssbus.ack <= ss_rd | ss_wr;
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [COLOR_W-1:0] color_s0 [NUM_LAYERS];
  logic [SEL_W-1:0]   sel_s0   [NUM_LAYERS];
  logic [15:0]        tbl_s0   [NUM_LAYERS];
  logic [15:0]        nib_s0   [NUM_LAYERS];
  logic [3:0]         prio_s0  [NUM_LAYERS];

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      color_s0[k] = color_in[k*SLICE_W +: COLOR_W];
      sel_s0[k]   = color_in[k*SLICE_W + COLOR_W +: SEL_W];
      tbl_s0[k]   = {live[3+2*k], live[2+2*k]};
      nib_s0[k]   = tbl_s0[k] >> {sel_s0[k], 2'b00};
      // pen 0 of a palette line is transparent
      prio_s0[k]  = (color_s0[k][3:0] != 4'd0) ? nib_s0[k][3:0] : 4'd0;
      if (MASK_EN && live[1][k]) prio_s0[k] = 4'd0;
    end
  end

  logic [3:0]         p1_prio  [NUM_LAYERS];
  logic [COLOR_W-1:0] p1_color [NUM_LAYERS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        p1_prio[k]  <= '0;
        p1_color[k] <= '0;
      end
    end else if (ce_pixel) begin
      for (int k = 0; k < NUM_LAYERS; k++) begin
        p1_prio[k]  <= prio_s0[k];
        p1_color[k] <= color_s0[k];
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [3:0]         w_prio, r_prio;
  logic [2:0]         w_idx;
  logic [COLOR_W-1:0] w_color, r_color;
  logic               r_found;

  // strict '>' while scanning upward gives ties to the lower index and leaves
  // layer 0 as the winner when every layer is transparent
  always_comb begin
    w_prio  = p1_prio[0];
    w_color = p1_color[0];
    w_idx   = 3'd0;
    for (int k = 1; k < NUM_LAYERS; k++) begin
      if (p1_prio[k] > w_prio) begin
        w_prio  = p1_prio[k];
        w_color = p1_color[k];
        w_idx   = 3'(k);
      end
    end
    r_prio  = '0;
    r_color = '0;
    r_found = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (3'(k) != w_idx && (!r_found || p1_prio[k] > r_prio)) begin
        r_found = 1'b1;
        r_prio  = p1_prio[k];
        r_color = p1_color[k];
      end
    end
  end

  logic blend_hit;
  assign blend_hit = live[0][7] & (r_prio != 4'd0) &
                     ({1'b0, w_prio} == ({1'b0, r_prio} + 5'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_out <= '0;
      layer_out <= '0;
    end else if (ce_pixel) begin
      color_out <= blend_hit ? {r_color[COLOR_W-1:4], w_color[3:0]} : w_color;
      layer_out <= w_idx;
    end
  end

  logic unused;
  assign unused = ^{cpu_ds_n[1], live[0][6:0], live[1]};

endmodule

// File: doc/prio_mixer_n.md
Name: prio_mixer_n

Overview:
- Parametrised N-layer successor to the two-plus-one-layer Taito priority mixer.
- Per pixel, takes NUM_LAYERS palette indices, each carrying a palette-select field. Looks up a per-layer priority nibble and selects the highest-priority opaque layer.
- Optionally nibble-blends the winner with the runner-up.
- CPU-visible registers are double-buffered and committed at vblank. Sits between tilemap/sprite mixers and the palette RAM.

Parameters:
- NUM_LAYERS, 4, number of input layers (2..7).
- COLOR_W, 12, palette index width per layer (>=5).
- SEL_W, 2, palette-select field width per layer; the priority table holds 2^SEL_W nibbles.
- ADDR_W, 4, CPU register address width.
- SS_IDX, -1, save-state bus slave index.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce_pixel  in  1  pixel clock enable
- vblank  in  1  vertical blank, level
- cs  in  1  CPU register select
- cpu_addr  in  ADDR_W  register address
- cpu_rw  in  1  1=read, 0=write
- cpu_ds_n  in  2  data strobes, active low; only bit 0 is used
- cpu_din  in  8  write data
- cpu_dout  out  8  read data, registered
- color_in  in  NUM_LAYERS*(SEL_W+COLOR_W)  layer k occupies slice k; within a slice, {sel, color}
- color_out  out  COLOR_W  final palette index
- layer_out  out  3  index of the winning layer (debug/shadow use)
- ssbus  ssbus_if.slave  -  save-state access to the staged register file

Behaviour:
- Register file, 2+2*NUM_LAYERS bytes:
  - reg0: bit7 blend_en; bit6 latch_mode (0 = staged copy is live immediately; 1 = commit to the live copy on the vblank rising edge).
  - reg1: reserved (layer mask when LAYER_MASK_EN).
  - reg(2+2k), reg(3+2k): prio table of layer k as {reg(3+2k), reg(2+2k)}. Nibble s is the priority for sel=s.
- Write: cs & ~cpu_rw & ~cpu_ds_n[0] writes cpu_din to the staged reg. Addresses past the map are ignored.
- Read: cs & cpu_rw loads cpu_dout next clk with the staged reg. Unmapped addresses read 0.
- ssbus: reads and writes the staged copy, size = 2+2*NUM_LAYERS. The live copy is recopied at the next commit.
- Commit:
  - With latch_mode=0, the live copy equals staged every clk.
  - With latch_mode=1, the live copy copies staged on the clk where vblank is 1 and was 0 on the previous clk. Edge detection runs on clk, not ce_pixel.
  - A CPU write on the commit clk is not committed until the next edge.
- Stage 1 (on ce_pixel):
  - prio_k = live table nibble[sel_k] if color_k[3:0] != 0, else 0.
  - Register prio_k and color_k for all layers.
- Stage 2 (on ce_pixel):
  - Winner W = layer with max prio. Tie goes to the lower index.
  - If all prio are 0, W = layer 0 (background passthrough).
  - Runner-up R = max prio among layers != W, same tie rule.
  - color_out = color_W, except when blend_en & prio_R != 0 & prio_W == prio_R+1: color_out = {color_R[COLOR_W-1:4], color_W[3:0]}.
  - layer_out = W.
- Latency: exactly 2 ce_pixel pulses from input to color_out. Outputs hold between pulses.
- Priority arithmetic is 4-bit unsigned; prio_R+1 is computed in 5 bits (15+1 never matches).
- Reset (async):
  - All regs, both copies, and all pipeline registers go to 0.
  - cpu_dout=0, color_out=0, layer_out=0.
  - Reset mid-frame also clears vblank edge history; the first vblank high after reset counts as a rising edge.

Optional Feature:
- PRIO_LAYER_MASK_EN defined: reg1 bits [NUM_LAYERS-1:0] form a live layer mask (double-buffered like the other regs). A set bit forces that layer's prio to 0 in stage 1. reg1 reads back its value.
- Undefined: reg1 writes are ignored, reads return 0, and no masking logic is built.

Test Plan:
- Reset, then 4 layers all color=0x000 -> after 2 ce_pixel, color_out=0x000, layer_out=0. cpu_dout=0x00 on a read of reg5.
- latch_mode=0; layer1 table=0x0004, sel=0, color 0x123; layer2 table=0x0007, color 0x456 -> color_out=0x456, layer_out=2. Set layer2 color 0x450 (transparent) -> 0x123 two pulses later.
- Tie: layers 1 and 3 both prio 5 -> layer_out=1.
- Blend: blend_en=1, W prio 6 color 0xABC, R prio 5 color 0x345 -> color_out=0x34C. Change R to prio 4 -> 0xABC.
- latch_mode=1: write layer2 table mid-frame -> output unchanged. Raise vblank -> new priority takes effect on the first pixel after commit. A write on the commit clk waits for the next vblank.
- PRIO_LAYER_MASK_EN: reg1=0x04 masks layer 2 (prio 7) -> layer 1 wins. Read reg1 -> 0x04.
